// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MIPS op encodings, the control state enum, and a
// two's-complement helper used for operand magnitudes and result sign fix-up.
package mul_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Widest value the helper handles; callers zero-extend into it and
    // size-cast the result back down.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } state_t;

    // Returns the magnitude of a two's-complement value whose sign is given
    // separately.  The low N bits of the result are correct for any
    // N <= MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] twos_abs(
        input logic [MAX_WIDTH-1:0] value,
        input logic                 is_neg
    );
        twos_abs = is_neg ? (~value + MAX_WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/mul_div_iter_core.sv
// Unsigned iterative datapath shared by multiply and divide.
//   clock, reset_n : clock and synchronous active-low reset
//   load           : start a new operation from op_a/op_b (also runs the first chunk)
//   step_en        : run one further chunk of STEPS_PER_CYCLE iterations
//   div_mode_in    : 1 = restoring divide, 0 = shift-add multiply (sampled on load)
//   op_a, op_b     : unsigned dividend/multiplier and divisor/multiplicand
//   acc_out        : remainder (divide) or product high half (multiply)
//   mq_out         : quotient (divide) or product low half (multiply)
module mul_div_iter_core
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step_en,
    input  logic             div_mode_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] mq_out
);

    logic [WIDTH-1:0] acc_q, mq_q, b_q;
    logic             mode_q;

    logic [WIDTH-1:0] acc_v, mq_v, b_v;
    logic             mode_v;
    logic [WIDTH:0]   sum_v, sh_v;

    always_comb begin
        acc_v  = load ? '0 : acc_q;
        mq_v   = load ? op_a : mq_q;
        b_v    = load ? op_b : b_q;
        mode_v = load ? div_mode_in : mode_q;
        sum_v  = '0;
        sh_v   = '0;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (mode_v) begin
                // Restoring divide: partial remainder stays below the divisor,
                // so the shifted value always fits in WIDTH+1 bits.
                sh_v = {acc_v, mq_v[WIDTH-1]};
                mq_v = {mq_v[WIDTH-2:0], 1'b0};
                if (sh_v >= {1'b0, b_v}) begin
                    sh_v    = sh_v - {1'b0, b_v};
                    mq_v[0] = 1'b1;
                end
                acc_v = sh_v[WIDTH-1:0];
            end else begin
                // Shift-add multiply: {acc, mq} shifts right, carry enters acc.
                sum_v = {1'b0, acc_v} + (mq_v[0] ? {1'b0, b_v} : '0);
                mq_v  = {sum_v[0], mq_v[WIDTH-1:1]};
                acc_v = sum_v[WIDTH:1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q  <= '0;
            mq_q   <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
        end else if (load || step_en) begin
            acc_q <= acc_v;
            mq_q  <= mq_v;
            if (load) begin
                b_q    <= op_b;
                mode_q <= div_mode_in;
            end
        end
    end

    assign acc_out = acc_q;
    assign mq_out  = mq_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO.
//   clock, reset_n        : clock and synchronous active-low reset
//   Start, Op             : launch mult/multu/div/divu (accepted when idle)
//   Operand_a, Operand_b  : rs / rt, sampled with Start
//   Mthi, Mtlo, Write_data: HI/LO writes, honoured only when idle
//   Cancel                : abort an in-flight operation without committing
//   Busy                  : operation in flight (stall request)
//   Done, Divide_zero     : one-cycle commit pulse and divide-by-zero flag
//   Hi, Lo                : architectural HI/LO registers
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_a,
    input  logic [WIDTH-1:0] Operand_b,
    input  logic             Mthi,
    input  logic             Mtlo,
    input  logic [WIDTH-1:0] Write_data,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic             Divide_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CHUNKS = WIDTH / STEPS_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(CHUNKS + 1);
    localparam int unsigned PW     = 2 * WIDTH;

    state_t state_q, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             res_neg_q, rem_neg_q;
    logic [CNT_W-1:0] count_q;
    logic             done_q, dz_q;

    logic             core_load, core_step;
    logic [WIDTH-1:0] core_acc, core_mq;

    logic             is_div, a_neg, b_neg, div_by_zero;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign is_div      = op_q[1];
    assign a_neg       = ~op_q[0] & a_q[WIDTH-1];
    assign b_neg       = ~op_q[0] & b_q[WIDTH-1];
    assign div_by_zero = is_div && (b_q == '0);

    assign abs_a = WIDTH'(twos_abs(MAX_WIDTH'(a_q), a_neg));
    assign abs_b = WIDTH'(twos_abs(MAX_WIDTH'(b_q), b_neg));

    assign prod_fix = PW'(twos_abs(MAX_WIDTH'({core_acc, core_mq}), res_neg_q));
    assign quot_fix = WIDTH'(twos_abs(MAX_WIDTH'(core_mq), res_neg_q));
    assign rem_fix  = WIDTH'(twos_abs(MAX_WIDTH'(core_acc), rem_neg_q));

    mul_div_iter_core #(
        .WIDTH           (WIDTH),
        .STEPS_PER_CYCLE (STEPS_PER_CYCLE)
    ) u_core (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (core_load),
        .step_en     (core_step),
        .div_mode_in (is_div),
        .op_a        (abs_a),
        .op_b        (abs_b),
        .acc_out     (core_acc),
        .mq_out      (core_mq)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PREP already runs the first chunk while loading the core, so CALC
    // only needs CHUNKS-1 cycles and Start-to-Done stays at CHUNKS+2.
    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && !Cancel) begin
                    state_d = PREP;
                end
            end
            PREP: begin
                if (Cancel || div_by_zero) begin
                    state_d = IDLE;
                end else begin
                    core_load = 1'b1;
                    state_d   = (CHUNKS == 1) ? FIX : CALC;
                end
            end
            CALC: begin
                if (Cancel) begin
                    state_d = IDLE;
                end else begin
                    core_step = 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= ((state_q == FIX) && !Cancel) ||
                      ((state_q == PREP) && !Cancel && div_by_zero);
            dz_q   <= (state_q == PREP) && !Cancel && div_by_zero;
            case (state_q)
                IDLE: begin
                    if (Mthi) begin
                        hi_q <= Write_data;
                    end
                    if (Mtlo) begin
                        lo_q <= Write_data;
                    end
                    if (Start && !Cancel) begin
                        op_q <= Op;
                        a_q  <= Operand_a;
                        b_q  <= Operand_b;
                    end
                end
                PREP: begin
                    res_neg_q <= a_neg ^ b_neg;
                    rem_neg_q <= a_neg;
                    count_q   <= CNT_W'(CHUNKS - 1);
                end
                CALC: begin
                    count_q <= count_q - CNT_W'(1);
                end
                FIX: begin
                    if (!Cancel) begin
                        if (is_div) begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy        = (state_q != IDLE);
    assign Done        = done_q;
    assign Divide_zero = dz_q;
    assign Hi          = hi_q;
    assign Lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level behavioural model of
// the default instance compared every cycle, directed vectors with literal
// expectations, and a STEPS_PER_CYCLE=4 instance with directed checks.
module tb_mul_div_unit;

    localparam int MAIN_LAT = 32 / 1 + 2;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, start, cancel, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    logic        q_reset_n, q_start, q_cancel, q_mthi, q_mtlo;
    logic [1:0]  q_op;
    logic [31:0] q_opa, q_opb, q_wdata;
    logic        q_busy, q_done, q_dz;
    logic [31:0] q_hi, q_lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit u_dut (
        .clock(clock), .reset_n(reset_n), .Start(start), .Op(op),
        .Operand_a(opa), .Operand_b(opb), .Mthi(mthi), .Mtlo(mtlo),
        .Write_data(wdata), .Cancel(cancel), .Busy(busy), .Done(done),
        .Divide_zero(dz), .Hi(hi), .Lo(lo)
    );

    mul_div_unit #(.WIDTH(32), .STEPS_PER_CYCLE(4)) u_dut4 (
        .clock(clock), .reset_n(q_reset_n), .Start(q_start), .Op(q_op),
        .Operand_a(q_opa), .Operand_b(q_opb), .Mthi(q_mthi), .Mtlo(q_mtlo),
        .Write_data(q_wdata), .Cancel(q_cancel), .Busy(q_busy), .Done(q_done),
        .Divide_zero(q_dz), .Hi(q_hi), .Lo(q_lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = '0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: if (b != 0) begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            default: if (b != 0) p = {a % b, a / b};
        endcase
        return p;
    endfunction

    // Cycle-level model of the default instance.
    logic        m_valid = 1'b0;
    logic        m_busy, m_done, m_dz, m_pend_dz;
    int          m_timer;
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;

    always @(posedge clock) begin
        logic [63:0] r;
        if (!reset_n) begin
            m_valid = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_pend_dz = 1'b0;
            m_timer = 0; m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0;
        end else if (m_valid) begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_busy) begin
                if (cancel) begin
                    m_busy = 1'b0;
                end else begin
                    m_timer--;
                    if (m_timer == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_dz   = m_pend_dz;
                        if (!m_pend_dz) begin
                            m_hi = m_rhi;
                            m_lo = m_rlo;
                        end
                    end
                end
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
                if (start && !cancel) begin
                    m_busy = 1'b1;
                    r = ref_result(op, opa, opb);
                    m_rhi = r[63:32];
                    m_rlo = r[31:0];
                    m_pend_dz = op[1] && (opb == 0);
                    m_timer = m_pend_dz ? 1 : MAIN_LAT - 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("divide_zero", 64'(dz), 64'(m_dz));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Called at a negedge; the current cycle is the Start cycle (cycle 0)
    // when first==1.  Returns the cycle index in which Done was seen.
    task automatic wait_done(input int first, input bit interfere,
                             output int lat, output logic saw_dz, output logic busy1);
        lat = -1; saw_dz = 1'b0; busy1 = 1'b0;
        for (int i = first; i <= 200; i++) begin
            @(negedge clock);
            if (i == 1) begin start = 1'b0; busy1 = busy; end
            if (interfere && i == 5) begin
                start = 1'b1; op = 2'b00; opa = 32'd99; opb = 32'd99;
                mtlo = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (interfere && i == 6) begin start = 1'b0; mtlo = 1'b0; mthi = 1'b0; end
            if (done) begin lat = i; saw_dz = dz; break; end
        end
        if (lat < 0) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere, output int lat, output logic saw_dz, output logic busy1);
        op = o; opa = a; opb = b; start = 1'b1;
        wait_done(1, interfere, lat, saw_dz, busy1);
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        mthi = h; mtlo = l; wdata = d;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    // multu 3*4 aborted at cycle 10 by Cancel or by reset.
    task automatic abort_op(input bit use_reset, output logic busy11);
        op = 2'b01; opa = 32'd3; opb = 32'd4; start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            if (i == 1) start = 1'b0;
            if (i == 10) begin
                if (use_reset) reset_n = 1'b0; else cancel = 1'b1;
            end
        end
        busy11 = busy;
        cancel = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic sdz, b1, b11, seen;
        reset_n = 1'b0; start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = '0; opa = '0; opb = '0; wdata = '0;
        q_reset_n = 1'b0; q_start = 1'b0; q_cancel = 1'b0; q_mthi = 1'b0; q_mtlo = 1'b0;
        q_op = '0; q_opa = '0; q_opb = '0; q_wdata = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        reset_n = 1'b1; q_reset_n = 1'b1;
        @(negedge clock);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, sdz, b1);
        check("mult_lat", 64'(lat), 64'(34));
        check("mult_busy_c1", 64'(b1), 64'(1));
        check("mult_busy_at_done", 64'(busy), 64'(0));
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFF1);

        run_op(2'b11, 32'd100, 32'd7, 1'b0, lat, sdz, b1);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, sdz, b1);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, sdz, b1);
        check("div_negb_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_negb_hi", 64'(hi), 64'd1);

        mt_write(1'b1, 1'b0, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, 1'b0, lat, sdz, b1);
        check("dz_lat", 64'(lat), 64'(2));
        check("dz_flag", 64'(sdz), 64'(1));
        check("dz_hi", 64'(hi), 64'h11);
        check("dz_lo", 64'(lo), 64'h22);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, sdz, b1);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'(0));
        check("ovf_noflag", 64'(sdz), 64'(0));

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, sdz, b1);
        check("mult_min_hi", 64'(hi), 64'h4000_0000);
        check("mult_min_lo", 64'(lo), 64'(0));

        mt_write(1'b1, 1'b0, 32'h1234_5678);
        check("mthi_next", 64'(hi), 64'h1234_5678);

        run_op(2'b01, 32'd6, 32'd7, 1'b1, lat, sdz, b1);
        check("busy_ignore_lat", 64'(lat), 64'(34));
        check("busy_ignore_hi", 64'(hi), 64'(0));
        check("busy_ignore_lo", 64'(lo), 64'd42);

        abort_op(1'b0, b11);
        check("cancel_busy11", 64'(b11), 64'(0));
        check("cancel_hi", 64'(hi), 64'(0));
        check("cancel_lo", 64'(lo), 64'd42);
        seen = 1'b0;
        repeat (40) begin @(negedge clock); if (done) seen = 1'b1; end
        check("cancel_no_done", 64'(seen), 64'(0));

        mt_write(1'b1, 1'b1, 32'h5555_AAAA);
        abort_op(1'b1, b11);
        check("reset_mid_busy", 64'(b11), 64'(0));
        check("reset_mid_hi", 64'(hi), 64'(0));
        check("reset_mid_lo", 64'(lo), 64'(0));
        @(negedge clock);

        start = 1'b1; cancel = 1'b1; op = 2'b01; opa = 32'd9; opb = 32'd9;
        @(negedge clock);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_idle", 64'(busy), 64'(0));
        @(negedge clock);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_AAAA;
        op = 2'b01; opa = 32'd2; opb = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("mt_start_hi", 64'(hi), 64'h0000_AAAA);
        check("mt_start_lo", 64'(lo), 64'h0000_AAAA);
        wait_done(2, 1'b0, lat, sdz, b1);
        check("mt_start_lat", 64'(lat), 64'(34));
        check("mt_start_res_hi", 64'(hi), 64'(0));
        check("mt_start_res_lo", 64'(lo), 64'd6);

        q_op = 2'b01; q_opa = 32'hFFFF_FFFF; q_opb = 32'hFFFF_FFFF; q_start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (i == 1) q_start = 1'b0;
            if (q_done) begin lat = i; break; end
        end
        check("s4_lat", 64'(lat), 64'(10));
        check("s4_hi", 64'(q_hi), 64'hFFFF_FFFE);
        check("s4_lo", 64'(q_lo), 64'h0000_0001);

        q_op = 2'b10; q_opa = 32'hFFFF_FFF9; q_opb = 32'd2; q_start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (i == 1) q_start = 1'b0;
            if (q_done) begin lat = i; break; end
        end
        check("s4_div_lat", 64'(lat), 64'(10));
        check("s4_div_lo", 64'(q_lo), 64'hFFFF_FFFD);
        check("s4_div_hi", 64'(q_hi), 64'hFFFF_FFFF);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
